// File: rtl/aes_job_scheduler.sv
// Round-robin job scheduler for an AES key-expansion/encipher engine with a
// one-entry expanded-key cache, completion watchdog and tagged response channel.
module aes_job_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [128*NUM_REQ-1:0]       req_block,
  input  logic [256*NUM_REQ-1:0]       req_key,
  input  logic [NUM_REQ-1:0]           req_keylen,
  input  logic [TAG_W*NUM_REQ-1:0]     req_tag,
  input  logic                         flush,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [TAG_W-1:0]             resp_tag,
  output logic [127:0]                 resp_block,
  output logic                         resp_err,
  output logic                         core_init,
  output logic                         core_next,
  output logic [255:0]                 core_key,
  output logic                         core_keylen,
  output logic [127:0]                 core_block,
  input  logic                         core_ready,
  input  logic [127:0]                 core_result,
  output logic                         busy
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int          NReq   = int'(NUM_REQ);
  localparam logic [7:0]  WdLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StKeyStart, StKeyWait, StEncStart, StEncWait, StResp
  } state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                 cache_valid_q, cache_valid_d;
  logic [255:0]         cache_key_q, cache_key_d;
  logic                 cache_keylen_q, cache_keylen_d;
  logic [127:0]         job_block_q, job_block_d;
  logic [255:0]         job_key_q, job_key_d;
  logic                 job_keylen_q, job_keylen_d;
  logic [TAG_W-1:0]     job_tag_q, job_tag_d;
  logic [IdW-1:0]       job_id_q, job_id_d;
  logic [7:0]           wd_q, wd_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [127:0]         resp_block_q, resp_block_d;
  logic                 resp_err_q, resp_err_d;
  logic                 core_init_q, core_init_d;
  logic                 core_next_q, core_next_d;
  logic                 busy_q, busy_d;

  // Arbitration: pick the valid requester closest to rr_ptr going upward.
  logic                 found;
  logic [IdW-1:0]       win;
  int                   best_dist;
  int                   cand_dist;

  always_comb begin
    found     = 1'b0;
    win       = '0;
    best_dist = NReq;
    cand_dist = 0;
    for (int j = 0; j < NReq; j++) begin
      cand_dist = j - int'(rr_ptr_q);
      if (cand_dist < 0) cand_dist = cand_dist + NReq;
      if (req_valid[j] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        win       = IdW'(j);
      end
    end
    found = (best_dist < NReq);
  end

  logic [127:0]     sel_block;
  logic [255:0]     sel_key;
  logic             sel_keylen;
  logic [TAG_W-1:0] sel_tag;
  logic             key_eq;
  logic             hit;

  always_comb begin
    sel_block  = '0;
    sel_key    = '0;
    sel_keylen = 1'b0;
    sel_tag    = '0;
    for (int i = 0; i < NReq; i++) begin
      if (win == IdW'(i)) begin
        sel_block  = req_block[128*i +: 128];
        sel_key    = req_key[256*i +: 256];
        sel_keylen = req_keylen[i];
        sel_tag    = req_tag[TAG_W*i +: TAG_W];
      end
    end
    // AES-128 keys live in the upper half; the lower half is don't-care.
    key_eq = sel_keylen ? (sel_key == cache_key_q)
                        : (sel_key[255:128] == cache_key_q[255:128]);
    hit    = cache_valid_q && (sel_keylen == cache_keylen_q) && key_eq;
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cache_valid_d  = cache_valid_q;
    cache_key_d    = cache_key_q;
    cache_keylen_d = cache_keylen_q;
    job_block_d    = job_block_q;
    job_key_d      = job_key_q;
    job_keylen_d   = job_keylen_q;
    job_tag_d      = job_tag_q;
    job_id_d       = job_id_q;
    wd_d           = wd_q;
    req_ready_d    = '0;
    resp_valid_d   = resp_valid_q;
    resp_block_d   = resp_block_q;
    resp_err_d     = resp_err_q;
    core_init_d    = 1'b0;
    core_next_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready_d  = NUM_REQ'(1) << win;
          job_block_d  = sel_block;
          job_key_d    = sel_key;
          job_keylen_d = sel_keylen;
          job_tag_d    = sel_tag;
          job_id_d     = win;
          rr_ptr_d     = (win == IdW'(NReq - 1)) ? '0 : win + 1'b1;
          if (hit) begin
            state_d     = StEncStart;
            core_next_d = 1'b1;
          end else begin
            state_d     = StKeyStart;
            core_init_d = 1'b1;
          end
        end
      end
      StKeyStart: begin
        state_d = StKeyWait;
        wd_d    = '0;
      end
      StKeyWait: begin
        wd_d = wd_q + 8'd1;
        if (core_ready) begin
          cache_valid_d  = 1'b1;
          cache_key_d    = job_key_q;
          cache_keylen_d = job_keylen_q;
          state_d        = StEncStart;
          core_next_d    = 1'b1;
        end else if (wd_q == WdLast) begin
          resp_err_d    = 1'b1;
          resp_block_d  = '0;
          resp_valid_d  = 1'b1;
          cache_valid_d = 1'b0;
          state_d       = StResp;
        end
      end
      StEncStart: begin
        state_d = StEncWait;
        wd_d    = '0;
      end
      StEncWait: begin
        wd_d = wd_q + 8'd1;
        if (core_ready) begin
          resp_block_d = core_result;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else if (wd_q == WdLast) begin
          // Engine state is unknown after a hang, so the cached key is dropped.
          resp_err_d    = 1'b1;
          resp_block_d  = '0;
          resp_valid_d  = 1'b1;
          cache_valid_d = 1'b0;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) cache_valid_d = 1'b0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      cache_valid_q  <= 1'b0;
      cache_key_q    <= '0;
      cache_keylen_q <= 1'b0;
      job_block_q    <= '0;
      job_key_q      <= '0;
      job_keylen_q   <= 1'b0;
      job_tag_q      <= '0;
      job_id_q       <= '0;
      wd_q           <= '0;
      req_ready_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_block_q   <= '0;
      resp_err_q     <= 1'b0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cache_valid_q  <= cache_valid_d;
      cache_key_q    <= cache_key_d;
      cache_keylen_q <= cache_keylen_d;
      job_block_q    <= job_block_d;
      job_key_q      <= job_key_d;
      job_keylen_q   <= job_keylen_d;
      job_tag_q      <= job_tag_d;
      job_id_q       <= job_id_d;
      wd_q           <= wd_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_block_q   <= resp_block_d;
      resp_err_q     <= resp_err_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      busy_q         <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = job_id_q;
  assign resp_tag    = job_tag_q;
  assign resp_block  = resp_block_q;
  assign resp_err    = resp_err_q;
  assign core_init   = core_init_q;
  assign core_next   = core_next_q;
  assign core_key    = job_key_q;
  assign core_keylen = job_keylen_q;
  assign core_block  = job_block_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: vector table of single jobs against a
// behavioural engine model, plus round-robin, backpressure/flush and reset sequences.
module tb_aes_job_scheduler;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_block;
  logic [511:0] req_key;
  logic [1:0]   req_keylen;
  logic [7:0]   req_tag;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [0:0]   resp_id;
  logic [3:0]   resp_tag;
  logic [127:0] resp_block;
  logic         resp_err;
  logic         core_init;
  logic         core_next;
  logic [255:0] core_key;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         busy;

  always #5 clk = ~clk;

  aes_job_scheduler #(.NUM_REQ(2), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
    .req_key(req_key), .req_keylen(req_keylen), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_block(resp_block), .resp_err(resp_err),
    .core_init(core_init), .core_next(core_next), .core_key(core_key),
    .core_keylen(core_keylen), .core_block(core_block), .core_ready(core_ready),
    .core_result(core_result), .busy(busy)
  );

  // Stand-in cipher: exact for the FIPS-197 vector, a keyed scramble otherwise.
  function automatic logic [127:0] fake_enc(input logic [255:0] k, input logic kl,
                                            input logic [127:0] b);
    logic [127:0] hi;
    hi = k[255:128];
    if (!kl && hi == FipsKey && b == FipsPt) return FipsCt;
    return {b[63:0], b[127:64]} ^ hi ^ (kl ? k[127:0] : 128'h0)
           ^ 128'h0123456789abcdef0f1e2d3c4b5a6978;
  endfunction

  // Engine model: keeps core_ready low for eng_delay cycles after each pulse.
  int           eng_delay = 1;
  int           eng_cnt;
  logic [255:0] eng_key;
  logic         eng_kl;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready  <= 1'b1;
      core_result <= '0;
      eng_cnt     <= 0;
      eng_key     <= '0;
      eng_kl      <= 1'b0;
    end else if (core_init) begin
      eng_key    <= core_key;
      eng_kl     <= core_keylen;
      core_ready <= 1'b0;
      eng_cnt    <= eng_delay;
    end else if (core_next) begin
      core_result <= fake_enc(eng_key, eng_kl, core_block);
      core_ready  <= 1'b0;
      eng_cnt     <= eng_delay;
    end else if (!core_ready) begin
      if (eng_cnt <= 1) core_ready <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  int init_cnt = 0;
  int next_cnt = 0;
  always @(posedge clk) begin
    if (core_init) init_cnt <= init_cnt + 1;
    if (core_next) next_cnt <= next_cnt + 1;
  end

  // Grant/response log; a grant must be one-hot and decided while not busy.
  int   grant_q[$];
  int   resp_q[$];
  int   mon_viol = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_ready != 2'b00) begin
        if (!$onehot(req_ready) || prev_busy) mon_viol <= mon_viol + 1;
        grant_q.push_back(req_ready[1] ? 1 : 0);
      end
      if (resp_valid && resp_ready) resp_q.push_back(int'(resp_id));
    end
    prev_busy <= busy;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int           id;
    logic [255:0] key;
    logic         kl;
    logic [127:0] blk;
    logic [3:0]   tag;
    int           dly;
    logic [127:0] ct;
    logic         err;
    int           inits;
    int           nexts;
    int           lat;
  } vec_t;

  function automatic vec_t mk(input int id, input logic [255:0] k, input logic kl,
                              input logic [127:0] b, input logic [3:0] t, input int dly,
                              input logic err, input int inits, input int nexts,
                              input int lat);
    vec_t v;
    v.id = id; v.key = k; v.kl = kl; v.blk = b; v.tag = t; v.dly = dly;
    v.ct = err ? 128'h0 : fake_enc(k, kl, b);
    v.err = err; v.inits = inits; v.nexts = nexts; v.lat = lat;
    return v;
  endfunction

  task automatic set_req(input int id, input logic [255:0] k, input logic kl,
                         input logic [127:0] b, input logic [3:0] t);
    req_key[256*id +: 256]  = k;
    req_keylen[id]          = kl;
    req_block[128*id +: 128] = b;
    req_tag[4*id +: 4]      = t;
  endtask

  // Issues one job with resp_ready high; returns one cycle after the handshake.
  task automatic run_job(input vec_t v, input string nm);
    int cyc;
    int i0;
    int n0;
    bit got;
    eng_delay = v.dly;
    i0 = init_cnt;
    n0 = next_cnt;
    set_req(v.id, v.key, v.kl, v.blk, v.tag);
    req_valid[v.id] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (req_ready[v.id]) req_valid[v.id] = 1'b0;
      if (resp_valid) got = 1'b1;
    end
    req_valid = 2'b00;
    check({nm, "_resp_seen"}, 256'(got), 256'(1));
    check({nm, "_id"},    256'(resp_id), 256'(v.id));
    check({nm, "_tag"},   256'(resp_tag), 256'(v.tag));
    check({nm, "_block"}, 256'(resp_block), 256'(v.ct));
    check({nm, "_err"},   256'(resp_err), 256'(v.err));
    check({nm, "_inits"}, 256'(init_cnt - i0), 256'(v.inits));
    check({nm, "_nexts"}, 256'(next_cnt - n0), 256'(v.nexts));
    check({nm, "_latency"}, 256'(cyc), 256'(v.lat));
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] kf;
    logic [255:0] kf2;
    logic [255:0] k256;
    logic [255:0] k256b;
    logic [255:0] k3;
    logic [255:0] k4;
    int g0;
    int r0;
    int cyc;
    bit got;
    int i0;

    kf    = {FipsKey, 128'h0};
    kf2   = {FipsKey, 128'hdeadbeefdeadbeefdeadbeefdeadbeef};
    k256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    k256b = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff5;
    k3    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k4    = {128'h11112222333344445555666677778888, 128'h0};

    // Hit latency = D+3; miss latency = 2D+5; watchdog abort = TIMEOUT+2.
    vecs[0]  = mk(0, kf,    1'b0, FipsPt, 4'h3, 5,  1'b0, 1, 1, 15);
    vecs[1]  = mk(1, kf,    1'b0, 128'hcafef00d_00000001_12345678_9abcdef0, 4'h9, 4,
                  1'b0, 0, 1, 7);
    vecs[2]  = mk(0, kf2,   1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 4'h1, 2,
                  1'b0, 0, 1, 5);
    vecs[3]  = mk(1, k256,  1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 4'h7, 3,
                  1'b0, 1, 1, 11);
    vecs[4]  = mk(0, k256b, 1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 4'h2, 1,
                  1'b0, 1, 1, 7);
    vecs[5]  = mk(1, k256b, 1'b0, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 4'hc, 2,
                  1'b0, 1, 1, 9);
    vecs[6]  = mk(1, k256b, 1'b0, 128'hf69f2445df4f9b17ad2b417be66c3710, 4'hd, 1,
                  1'b0, 0, 1, 4);
    vecs[7]  = mk(1, k3,    1'b0, 128'h3243f6a8885a308d313198a2e0370734, 4'h4, 2,
                  1'b0, 1, 1, 9);
    vecs[8]  = mk(0, k3,    1'b0, 128'h00000000000000000000000000000001, 4'h8, 70,
                  1'b1, 0, 1, 66);
    vecs[9]  = mk(1, k3,    1'b0, 128'h00000000000000000000000000000002, 4'ha, 2,
                  1'b0, 1, 1, 9);
    vecs[10] = mk(0, k4,    1'b0, 128'h00000000000000000000000000000003, 4'hb, 70,
                  1'b1, 1, 0, 66);
    vecs[11] = mk(1, k4,    1'b0, 128'h00000000000000000000000000000004, 4'he, 1,
                  1'b0, 1, 1, 7);

    reset_n    = 1'b0;
    req_valid  = 2'b00;
    req_block  = '0;
    req_key    = '0;
    req_keylen = '0;
    req_tag    = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", 256'({req_ready, resp_valid, resp_id, resp_tag, resp_err, core_init,
                             core_next, core_keylen, busy}), 256'(0));
    check("reset_key", core_key, 256'(0));
    check("reset_blk", {core_block, resp_block}, 256'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Both requesters held valid from rr_ptr = 0: grants must alternate.
    eng_delay = 1;
    g0 = grant_q.size();
    r0 = resp_q.size();
    set_req(0, k4, 1'b0, 128'h00000000000000000000000000000010, 4'h5);
    set_req(1, k4, 1'b0, 128'h00000000000000000000000000000011, 4'h6);
    req_valid = 2'b11;
    cyc = 0;
    while (cyc < 200 && (grant_q.size() - g0) < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 2'b00;
    cyc = 0;
    while (cyc < 100 && (busy || resp_valid)) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check("rr_grant_count", 256'(grant_q.size() - g0), 256'(4));
    check("rr_resp_count", 256'(resp_q.size() - r0), 256'(4));
    for (int k = 0; k < 4; k++) begin
      if (g0 + k < grant_q.size())
        check($sformatf("rr_grant%0d", k), 256'(grant_q[g0 + k]), 256'(k % 2));
      if (r0 + k < resp_q.size())
        check($sformatf("rr_resp%0d", k), 256'(resp_q[r0 + k]), 256'(k % 2));
    end

    // Backpressure: response held 10 cycles, a pending requester is not granted,
    // and a flush inside the window forces the next same-key job to expand again.
    eng_delay  = 2;
    resp_ready = 1'b0;
    set_req(0, k4, 1'b0, 128'h000000000000000000000000000000a5, 4'h5);
    req_valid[0] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 100 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (req_ready[0]) begin
        req_valid[0] = 1'b0;
        set_req(1, k4, 1'b0, 128'h000000000000000000000000000000b6, 4'h6);
        req_valid[1] = 1'b1;
      end
      if (resp_valid) got = 1'b1;
    end
    check("bp_resp_seen", 256'(got), 256'(1));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold%0d", k),
            256'({resp_block, resp_valid, resp_id, resp_tag, resp_err, req_ready}),
            256'({fake_enc(k4, 1'b0, 128'h000000000000000000000000000000a5),
                  1'b1, 1'b0, 4'h5, 1'b0, 2'b00}));
      flush = (k == 3);
      @(posedge clk); #1;
    end
    flush        = 1'b0;
    resp_ready   = 1'b1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("bp_released", 256'(resp_valid), 256'(0));
    run_job(mk(1, k4, 1'b0, 128'h000000000000000000000000000000b6, 4'h6, 2, 1'b0, 1, 1, 9),
            "post_flush");

    // Reset in the middle of ENC_WAIT aborts silently and clears the key cache.
    eng_delay = 20;
    set_req(0, k4, 1'b0, 128'h000000000000000000000000000000c7, 4'h7);
    req_valid[0] = 1'b1;
    cyc = 0;
    while (cyc < 50 && !req_ready[0]) begin
      @(posedge clk); #1;
      cyc++;
    end
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", 256'({busy, resp_valid}), 256'(2'b10));
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ctl", 256'({req_ready, resp_valid, resp_id, resp_tag, resp_err, core_init,
                               core_next, core_keylen, busy}), 256'(0));
    check("rst_mid_key", core_key, 256'(0));
    check("rst_mid_blk", {core_block, resp_block}, 256'(0));
    reset_n = 1'b1;
    i0 = resp_q.size();
    @(posedge clk); #1;
    check("rst_no_resp", 256'(resp_q.size() - i0), 256'(0));
    run_job(mk(0, k4, 1'b0, 128'h000000000000000000000000000000d8, 4'h8, 2, 1'b0, 1, 1, 9),
            "post_reset");

    check("grant_onehot_idle", 256'(mon_viol), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
